// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and line levels.
// Used by both the transmit serializer and the matching receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ALIGN  = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } uart_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Valid/ready word handshake between an upstream producer and the UART serializer.
interface uart_tx_serializer_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: accepts a word by valid/ready and shifts it out LSB-first
// as start, data, optional parity and stop bits, one bit per prescaler tick.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                  src_clk,
    input  logic                  rst,
    input  logic                  baud_tick,
    output logic                  baud_en,
    uart_tx_serializer_if.slave   s_if,
    output logic                  tx,
    output logic                  tx_done
);

    localparam int unsigned CNT_W = $clog2(DATA_BITS) + 1;

    uart_state_e          r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic                 r_stop_cnt;
    logic                 r_parity;
    logic                 r_tx;
    logic                 r_ready;
    logic                 r_en;

    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 w_last_data;
    logic                 w_last_stop;
    logic                 w_take;

    assign w_shift_nxt = r_shift >> 1;
    assign w_last_data = (r_bit_cnt == CNT_W'(DATA_BITS - 1));
    assign w_last_stop = (r_stop_cnt == 1'(STOP_BITS - 1));
    assign w_take      = s_if.tx_valid && r_ready;

    assign s_if.tx_ready = r_ready;
    assign baud_en       = r_en;
    assign tx            = r_tx;
    // Done coincides with the tick ending the last stop bit, so ready rises the cycle after.
    assign tx_done = !rst && (r_state == ST_STOP) && baud_tick && w_last_stop;

    always_ff @(posedge src_clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_parity   <= 1'b0;
            r_tx       <= IDLE_LEVEL;
            r_ready    <= 1'b1;
            r_en       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_shift  <= s_if.tx_data;
                        r_parity <= (^s_if.tx_data) ^ (PARITY == PAR_ODD);
                        r_state  <= ST_ALIGN;
                        r_ready  <= 1'b0;
                        r_en     <= 1'b1;
                    end
                end
                // Prescaler count is frozen until en rises, so wait one tick for a full start bit.
                ST_ALIGN: begin
                    if (baud_tick) begin
                        r_state <= ST_START;
                        r_tx    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        r_state   <= ST_DATA;
                        r_bit_cnt <= '0;
                        r_tx      <= r_shift[0];
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        r_shift   <= w_shift_nxt;
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        if (!w_last_data) begin
                            r_tx <= w_shift_nxt[0];
                        end else if (PARITY != PAR_NONE) begin
                            r_state <= ST_PARITY;
                            r_tx    <= r_parity;
                        end else begin
                            r_state    <= ST_STOP;
                            r_stop_cnt <= 1'b0;
                            r_tx       <= IDLE_LEVEL;
                        end
                    end
                end
                ST_PARITY: begin
                    if (baud_tick) begin
                        r_state    <= ST_STOP;
                        r_stop_cnt <= 1'b0;
                        r_tx       <= IDLE_LEVEL;
                    end
                end
                ST_STOP: begin
                    if (baud_tick) begin
                        if (w_last_stop) begin
                            r_state <= ST_IDLE;
                            r_ready <= 1'b1;
                            r_en    <= 1'b0;
                        end else begin
                            r_stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= IDLE_LEVEL;
                    r_ready <= 1'b1;
                    r_en    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Randomized bench for four serializer configurations (8N1, 8E1, 8O1, 8N2) sharing one
// stimulus stream, checked cycle by cycle against a tick-counting frame model.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic       tb_valid;
    logic [7:0] tb_data;
    logic [3:0] en_w, tx_w, done_w, ready_w;

    always #5 clk = ~clk;

    uart_tx_serializer_if #(.DATA_BITS(8)) if0 ();
    uart_tx_serializer_if #(.DATA_BITS(8)) if1 ();
    uart_tx_serializer_if #(.DATA_BITS(8)) if2 ();
    uart_tx_serializer_if #(.DATA_BITS(8)) if3 ();

    assign if0.tx_valid = tb_valid;  assign if0.tx_data = tb_data;  assign ready_w[0] = if0.tx_ready;
    assign if1.tx_valid = tb_valid;  assign if1.tx_data = tb_data;  assign ready_w[1] = if1.tx_ready;
    assign if2.tx_valid = tb_valid;  assign if2.tx_data = tb_data;  assign ready_w[2] = if2.tx_ready;
    assign if3.tx_valid = tb_valid;  assign if3.tx_data = tb_data;  assign ready_w[3] = if3.tx_ready;

    uart_tx_serializer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .src_clk(clk), .rst(rst), .baud_tick(baud_tick), .baud_en(en_w[0]),
        .s_if(if0.slave), .tx(tx_w[0]), .tx_done(done_w[0]));
    uart_tx_serializer #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
        .src_clk(clk), .rst(rst), .baud_tick(baud_tick), .baud_en(en_w[1]),
        .s_if(if1.slave), .tx(tx_w[1]), .tx_done(done_w[1]));
    uart_tx_serializer #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8o1 (
        .src_clk(clk), .rst(rst), .baud_tick(baud_tick), .baud_en(en_w[2]),
        .s_if(if2.slave), .tx(tx_w[2]), .tx_done(done_w[2]));
    uart_tx_serializer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
        .src_clk(clk), .rst(rst), .baud_tick(baud_tick), .baud_en(en_w[3]),
        .s_if(if3.slave), .tx(tx_w[3]), .tx_done(done_w[3]));

    // Reference model: a frame is a list of serial bits; position = ticks seen since handshake.
    int          pm[4] = '{0, 1, 2, 0};
    int          sb[4] = '{1, 1, 1, 2};
    int          flen[4];
    bit          busy[4];
    int          n[4];
    logic [11:0] bits[4];
    int          exp_frames[4];
    int          obs_done[4];
    int          total = 0;
    int          bad = 0;
    int          tick_phase = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] frame_bits(input int i, input logic [7:0] d);
        logic [11:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int j = 0; j < 8; j++) f[1 + j] = d[j];
        if (pm[i] != 0) f[9] = (^d) ^ (pm[i] == 2);
        return f;
    endfunction

    // One clock: drive inputs, check tx_done, advance model at posedge, check line state after.
    task automatic drive_cycle(input logic v, input logic [7:0] d, input logic r);
        logic exp_done;
        logic exp_tx;
        tick_phase = (tick_phase + 1) % 4;
        baud_tick  = (tick_phase == 0);
        tb_valid   = v;
        tb_data    = d;
        rst        = r;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_done = !r && busy[i] && baud_tick && (n[i] == flen[i]);
            check_eq($sformatf("done%0d", i), 32'(done_w[i]), 32'(exp_done));
            if (done_w[i] === 1'b1) obs_done[i]++;
        end
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (r) begin
                busy[i] = 1'b0;
                n[i]    = 0;
            end else if (busy[i]) begin
                if (baud_tick) begin
                    n[i]++;
                    if (n[i] > flen[i]) begin
                        busy[i] = 1'b0;
                        exp_frames[i]++;
                    end
                end
            end else if (v) begin
                busy[i] = 1'b1;
                n[i]    = 0;
                bits[i] = frame_bits(i, d);
            end
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            exp_tx = (busy[i] && n[i] > 0) ? bits[i][n[i] - 1] : 1'b1;
            check_eq($sformatf("tx%0d", i),    32'(tx_w[i]),    32'(exp_tx));
            check_eq($sformatf("ready%0d", i), 32'(ready_w[i]), 32'(!busy[i]));
            check_eq($sformatf("en%0d", i),    32'(en_w[i]),    32'(busy[i]));
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (ready_w === 4'hF) begin
                ok = 1'b1;
                break;
            end
            drive_cycle(1'b0, 8'($urandom), 1'b0);
        end
        if (!ok) check_eq("idle_timeout", 32'(ready_w), 32'hF);
    endtask

    // Handshake placed so the next tick lands k cycles after the handshake cycle.
    task automatic send(input logic [7:0] d, input int k);
        wait_idle();
        for (int c = 0; c < 8 && ((tick_phase + 1 + k) % 4) != 0; c++)
            drive_cycle(1'b0, 8'($urandom), 1'b0);
        drive_cycle(1'b1, d, 1'b0);
    endtask

    logic [7:0] words[6] = '{8'hA5, 8'h07, 8'h00, 8'h3C, 8'hA5, 8'h5A};

    initial begin
        for (int i = 0; i < 4; i++) begin
            flen[i]       = 1 + 8 + ((pm[i] != 0) ? 1 : 0) + sb[i];
            busy[i]       = 1'b0;
            n[i]          = 0;
            bits[i]       = '1;
            exp_frames[i] = 0;
            obs_done[i]   = 0;
        end
        tb_valid  = 1'b0;
        tb_data   = '0;
        baud_tick = 1'b0;
        rst       = 1'b1;

        for (int c = 0; c < 3; c++) drive_cycle(1'b1, 8'hFF, 1'b1);

        // Directed words across all four tick alignments.
        for (int w = 0; w < 6; w++) send(words[w], w % 4);
        wait_idle();

        // Reset during data bit 3 of the 8N1 frame, then a clean frame.
        send(8'hFF, 1);
        for (int c = 0; c < 100 && !(busy[0] && n[0] == 5); c++)
            drive_cycle(1'b0, 8'($urandom), 1'b0);
        check_eq("rst_reach_bit3", 32'(n[0]), 32'd5);
        drive_cycle(1'b0, 8'h00, 1'b1);
        check_eq("rst_tx", 32'(tx_w[0]), 32'd1);
        send(8'h3C, 3);
        wait_idle();

        // Valid held high: 0x55 first, then 0xAA must wait for the first idle cycle.
        drive_cycle(1'b1, 8'h55, 1'b0);
        for (int c = 0; c < 120; c++) drive_cycle(1'b1, 8'hAA, 1'b0);
        wait_idle();

        // Random traffic with occasional resets.
        for (int c = 0; c < 4000; c++)
            drive_cycle(($urandom % 3) == 0, 8'($urandom), ($urandom % 400) == 0);
        wait_idle();

        for (int i = 0; i < 4; i++)
            check_eq($sformatf("done_count%0d", i), 32'(obs_done[i]), 32'(exp_frames[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
